alarm_zone_controller: RTL

Parametrised successor to the single-vehicle alarm FSM. It supervises NUM_ZONES door/hatch zones, each of which can be bypassed, and owns its own countdown timer driven by an external 1 Hz tick. It keeps four reprogrammable delays and latches which zones caused an alarm. It sits between the debouncer bank and the siren/status drivers in the top level.

---
 rtl/alarm_zone_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alarm_zone_controller.sv
// alarm_zone_controller: multi-zone vehicle alarm FSM with bypass, reprogrammable delays and 1 Hz countdown timer
// Ports:
//   clock, reset (async active-low), tick_1hz (1 s pulse), ignition
//   zone_open / zone_bypass [NUM_ZONES]: zone open flags and trigger bypass mask
//   reprogram, param_sel, param_value: delay register write, forces ARMED
//   status (LED), siren_en, alarm_zones (latched cause), state, timer_value
module alarm_zone_controller #(
    parameter int NUM_ZONES    = 4,
    parameter int TW           = 4,
    parameter int DEF_ARM      = 6,
    parameter int DEF_DRIVER   = 8,
    parameter int DEF_PASS     = 15,
    parameter int DEF_ALARM_ON = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick_1hz,
    input  logic                 ignition,
    input  logic [NUM_ZONES-1:0] zone_open,
    input  logic [NUM_ZONES-1:0] zone_bypass,
    input  logic                 reprogram,
    input  logic [1:0]           param_sel,
    input  logic [TW-1:0]        param_value,
    output logic                 status,
    output logic                 siren_en,
    output logic [NUM_ZONES-1:0] alarm_zones,
    output logic [2:0]           state,
    output logic [TW-1:0]        timer_value
);
    typedef enum logic [2:0] {
        ARMED     = 3'd0,
        DISARMED  = 3'd1,
        TRIGGERED = 3'd2,
        SOUNDING  = 3'd3,
        HOLD      = 3'd4,
        DOOR_OPEN = 3'd5,
        ARMING    = 3'd6
    } state_t;

    state_t               st, nst;
    logic [TW-1:0]        count, load_val;
    logic [TW-1:0]        delay [4];
    logic                 running, load, stop, expired, siren_next, status_next;
    logic [NUM_ZONES-1:0] active, az_next;

    assign active      = zone_open & ~zone_bypass;
    assign expired     = running && count == '0;
    assign state       = st;
    assign timer_value = count;

    always_comb begin
        nst      = st;
        load     = 1'b0;
        load_val = '0;
        stop     = 1'b0;
        az_next  = alarm_zones;
        if (reprogram) begin
            nst     = ARMED;
            stop    = 1'b1;
            az_next = '0;
        end else if (ignition && st != DISARMED) begin
            nst  = DISARMED;
            stop = 1'b1;
        end else begin
            case (st)
                ARMED: begin
                    az_next = alarm_zones | active;
                    if (active != '0) begin
                        nst      = TRIGGERED;
                        load     = 1'b1;
                        load_val = active[0] ? delay[1] : delay[2];
                    end
                end
                TRIGGERED: begin
                    az_next = alarm_zones | active;
                    nst     = expired ? SOUNDING : TRIGGERED;
                end
                SOUNDING: begin
                    az_next = alarm_zones | active;
                    if (active == '0) begin
                        nst      = HOLD;
                        load     = 1'b1;
                        load_val = delay[3];
                    end
                end
                HOLD: begin
                    if (active != '0) begin
                        nst  = SOUNDING;
                        stop = 1'b1;
                    end else if (expired) nst = ARMED;
                end
                DISARMED: nst = (!ignition && zone_open[0]) ? DOOR_OPEN : DISARMED;
                DOOR_OPEN: begin
                    if (zone_open == '0) begin
                        nst      = ARMING;
                        load     = 1'b1;
                        load_val = delay[0];
                    end
                end
                ARMING: begin
                    if (zone_open != '0) begin
                        nst  = DOOR_OPEN;
                        stop = 1'b1;
                    end else if (expired) begin
                        nst     = ARMED;
                        az_next = '0;
                    end
                end
                default: nst = ARMED;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    // Status blinks only while remaining in ARMED; entering ARMED restarts it dark.
    assign siren_next  = nst == SOUNDING || nst == HOLD;
    assign status_next = (nst == TRIGGERED || siren_next) ? 1'b1 :
                         (nst == ARMED && st == ARMED) ? status ^ tick_1hz : 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st          <= ARMED;
            count       <= '0;
            running     <= 1'b0;
            alarm_zones <= '0;
            status      <= 1'b0;
            siren_en    <= 1'b0;
            delay[0]    <= TW'(DEF_ARM);
            delay[1]    <= TW'(DEF_DRIVER);
            delay[2]    <= TW'(DEF_PASS);
            delay[3]    <= TW'(DEF_ALARM_ON);
        end else begin
            st          <= nst;
            alarm_zones <= az_next;
            status      <= status_next;
            siren_en    <= siren_next;
            if (reprogram) delay[param_sel] <= (param_value == '0) ? TW'(1) : param_value;
            // Load beats a coincident tick; expiry drops running one cycle after count hits 0.
            if (load) begin
                count   <= load_val;
                running <= 1'b1;
            end else if (stop || expired) running <= 1'b0;
            else if (running && tick_1hz && count != '0) count <= count - TW'(1);
        end
    end
endmodule
